reg_bank: RTL and testbench
===========================

# reg_bank

Register-file storage array that sits directly downstream of the 5-bit-to-32-bit one-hot write decoder. It consumes the decoder's one-hot write-select vector and holds 32 registers of WD bits. Register 0 is hardwired to zero, consistent with the decoder mapping address 0 to an all-zero vector. The block provides one write port and two registered read ports with a read-valid handshake, an optional write-to-read bypass, and a sticky error flag for illegal multi-hot write selects.

## Interface
- WD, default my_pkg::WD (32), data width and one-hot vector width
- SEL, default my_pkg::SEL (5), read-select width; NREG = 2**SEL = 32 registers
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  reset, synchronous, active-high
- we  input  1  write strobe
- wr_onehot  input  WD  one-hot write select from the decoder; bit i selects register i
- wr_data  input  WD  write data
- rd_en  input  1  read request, applies to both ports
- rd_sel_a  input  SEL  read address, port A
- rd_sel_b  input  SEL  read address, port B
- rd_data_a  output  WD  registered read data, port A
- rd_data_b  output  WD  registered read data, port B
- rd_valid  output  1  rd_data_a/b hold the result of the previous-cycle request
- err_multi  output  1  sticky flag: a write was attempted with more than one select bit set

## Operation
- Storage: NREG x WD flops. reg[0] is constant 0 and never written. It reads 0 in all cases.
- Write: when we=1 and wr_onehot has exactly one bit i set with i≠0, reg[i] <= wr_data at the clock edge.
- we=1 with wr_onehot==0: no write, no error. This is the decoder's output for address 0.
- we=1 with wr_onehot bit 0 only set: no write, no error.
- we=1 with two or more bits set: no register is written. err_multi is set to 1 and holds until rst.
- we=0: wr_onehot and wr_data are ignored, including multi-hot values. err_multi is unaffected.
- Read: when rd_en=1, rd_data_a <= reg[rd_sel_a], rd_data_b <= reg[rd_sel_b], and rd_valid <= 1.
- When rd_en=0: rd_valid <= 0, and rd_data_a/b hold their previous values.
- Both ports may address the same register. Both return identical data.
- Reset: all reg[i] <= 0, rd_data_a/b <= 0, rd_valid <= 0, err_multi <= 0. Reset has priority over a simultaneous write or read.
- Reset asserted mid-stream: the request in the reset cycle is discarded, and rd_valid is 0 in the following cycle.

## Timing
- Write latency: 1 cycle. Data written at edge N is visible to a read request issued in cycle N+1, and appears on rd_data at edge N+2.
- Read latency: 1 cycle. A request in cycle N gives rd_data and rd_valid=1 after edge N+1.
- Same-cycle write and read of the same register: behaviour depends on REG_BYPASS_EN (see Configuration).
- err_multi rises 1 cycle after the offending write cycle.
- Back-to-back rd_en=1 cycles give a new result every cycle, with no bubbles.

## Configuration
- Macro REG_BYPASS_EN.
- Defined: a read port whose rd_sel matches the index of a legal single-hot write (index ≠ 0) in the same cycle returns wr_data. This is write-through forwarding.
- Not defined: that read port returns the pre-write register contents. The new value is visible from the next request.
- Neither mode forwards for index 0 or for a multi-hot write.

## Test plan
- Reset, then rd_en=1 with rd_sel_a=7 and rd_sel_b=31: next cycle rd_data_a=rd_data_b=0 and rd_valid=1.
- we=1, wr_onehot=32'h0000_0020, wr_data=32'hDEAD_BEEF, then read rd_sel_a=5: rd_data_a=32'hDEAD_BEEF.
- we=1, wr_onehot=0 or 32'h0000_0001, wr_data=32'hFFFF_FFFF, then read rd_sel_a=0: rd_data_a=0 and err_multi=0.
- we=1, wr_onehot=32'h0000_0300, wr_data=32'h1234_5678: err_multi=1 next cycle and stays 1. Reads of regs 8 and 9 return their prior values. After rst, err_multi=0.
- Same-cycle write reg 3 with 32'hA5A5_A5A5 (prior value 32'h0000_0011) and read rd_sel_a=3: next-cycle rd_data_a is 32'hA5A5_A5A5 with REG_BYPASS_EN defined, 32'h0000_0011 without it.
- rd_en pulsed high then low: rd_valid is 1 for one cycle, then 0, and rd_data holds its value. Assert rst during an active rd_en: rd_valid=0 and rd_data=0 the next cycle.

Source files
------------

// File: rtl/reg_bank.sv
// 32-entry register file behind the one-hot write decoder: one write port,
// two registered read ports, sticky multi-hot error. Optional macro: REG_BYPASS_EN.
package my_pkg;
   localparam int WD  = 32;
   localparam int SEL = 5;
endpackage

module reg_bank #(
   parameter int WD  = my_pkg::WD,
   parameter int SEL = my_pkg::SEL
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           we,
   input  logic [WD-1:0]  wr_onehot,
   input  logic [WD-1:0]  wr_data,
   input  logic           rd_en,
   input  logic [SEL-1:0] rd_sel_a,
   input  logic [SEL-1:0] rd_sel_b,
   output logic [WD-1:0]  rd_data_a,
   output logic [WD-1:0]  rd_data_b,
   output logic           rd_valid,
   output logic           err_multi
);

   localparam int NREG = 2**SEL;

   logic [WD-1:0]  regs_q [NREG];
   logic [WD-1:0]  regs_d [NREG];
   logic [WD-1:0]  rd_data_a_q, rd_data_a_d;
   logic [WD-1:0]  rd_data_b_q, rd_data_b_d;
   logic           rd_valid_q, rd_valid_d;
   logic           err_multi_q, err_multi_d;

   logic           sel_multi;
   logic           wr_legal;
   logic [SEL-1:0] wr_idx;
   logic [WD-1:0]  rd_src_a, rd_src_b;

   // x & (x-1) clears the lowest set bit; anything left means two or more bits set
   always_comb begin
      sel_multi = (wr_onehot & (wr_onehot - WD'(1))) != '0;
      wr_legal  = we && (wr_onehot != '0) && !sel_multi && !wr_onehot[0];
      wr_idx    = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (wr_onehot[i]) wr_idx = SEL'(i);
      end
   end

   always_comb begin
      regs_d = regs_q;
      if (wr_legal) regs_d[wr_idx] = wr_data;
      regs_d[0] = '0;
   end

   always_comb begin
      rd_src_a = regs_q[rd_sel_a];
      rd_src_b = regs_q[rd_sel_b];
`ifdef REG_BYPASS_EN
      if (wr_legal && (rd_sel_a == wr_idx)) rd_src_a = wr_data;
      if (wr_legal && (rd_sel_b == wr_idx)) rd_src_b = wr_data;
`endif
      rd_data_a_d = rd_en ? rd_src_a : rd_data_a_q;
      rd_data_b_d = rd_en ? rd_src_b : rd_data_b_q;
      rd_valid_d  = rd_en;
      err_multi_d = err_multi_q | (we & sel_multi);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
         rd_data_a_q <= '0;
         rd_data_b_q <= '0;
         rd_valid_q  <= 1'b0;
         err_multi_q <= 1'b0;
      end else begin
         regs_q      <= regs_d;
         rd_data_a_q <= rd_data_a_d;
         rd_data_b_q <= rd_data_b_d;
         rd_valid_q  <= rd_valid_d;
         err_multi_q <= err_multi_d;
      end
   end

   assign rd_data_a = rd_data_a_q;
   assign rd_data_b = rd_data_b_q;
   assign rd_valid  = rd_valid_q;
   assign err_multi = err_multi_q;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: array/queue-level model compared every
// cycle, plus directed literal checks. Honours REG_BYPASS_EN.
module tb_reg_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [31:0] wr_onehot;
   logic [31:0] wr_data;
   logic        rd_en;
   logic [4:0]  rd_sel_a;
   logic [4:0]  rd_sel_b;
   logic [31:0] rd_data_a;
   logic [31:0] rd_data_b;
   logic        rd_valid;
   logic        err_multi;

   int errors = 0;
   int checks = 0;

   reg_bank dut (
      .clk       (clk),
      .rst       (rst),
      .we        (we),
      .wr_onehot (wr_onehot),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_sel_a  (rd_sel_a),
      .rd_sel_b  (rd_sel_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .rd_valid  (rd_valid),
      .err_multi (err_multi)
   );

   always #5 clk = ~clk;

`ifdef REG_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   // behavioural model
   logic [31:0] m_regs [32];
   logic [31:0] m_a = '0, m_b = '0;
   logic        m_valid = 1'b0, m_err = 1'b0;

   always @(posedge clk) begin
      int          idx;
      bit          legal;
      logic [31:0] new_a, new_b;
      idx = -1;
      for (int k = 0; k < 32; k++) if (wr_onehot == (32'd1 << k)) idx = k;
      legal = we && (idx > 0);
      if (rst) begin
         for (int k = 0; k < 32; k++) m_regs[k] = '0;
         m_a = '0; m_b = '0; m_valid = 1'b0; m_err = 1'b0;
      end else begin
         new_a = m_regs[rd_sel_a];
         new_b = m_regs[rd_sel_b];
         if (BYPASS && legal && int'(rd_sel_a) == idx) new_a = wr_data;
         if (BYPASS && legal && int'(rd_sel_b) == idx) new_b = wr_data;
         if (rd_en) begin m_a = new_a; m_b = new_b; end
         m_valid = rd_en;
         if (we && $countones(wr_onehot) > 1) m_err = 1'b1;
         if (legal) m_regs[idx] = wr_data;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("model_valid", {31'd0, rd_valid}, {31'd0, m_valid});
      check("model_err", {31'd0, err_multi}, {31'd0, m_err});
      check("model_a", rd_data_a, m_a);
      check("model_b", rd_data_b, m_b);
   end

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic drive(input logic w, input logic [31:0] oh, input logic [31:0] d,
                        input logic r, input logic [4:0] sa, input logic [4:0] sb);
      we = w; wr_onehot = oh; wr_data = d; rd_en = r; rd_sel_a = sa; rd_sel_b = sb;
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      tick; tick;
      check("rst_valid", {31'd0, rd_valid}, 32'd0);
      check("rst_err", {31'd0, err_multi}, 32'd0);
      check("rst_a", rd_data_a, 32'd0);

      rst = 1'b0;
      drive(0, 0, 0, 1, 7, 31); tick;
      check("rd_after_rst_a", rd_data_a, 32'd0);
      check("rd_after_rst_b", rd_data_b, 32'd0);
      check("rd_after_rst_valid", {31'd0, rd_valid}, 32'd1);

      drive(1, 32'h0000_0020, 32'hDEAD_BEEF, 0, 0, 0); tick;
      drive(0, 0, 0, 1, 5, 5); tick;
      check("wr5_a", rd_data_a, 32'hDEAD_BEEF);
      check("wr5_b_same", rd_data_b, 32'hDEAD_BEEF);

      drive(1, 32'h0, 32'hFFFF_FFFF, 0, 0, 0); tick;
      drive(1, 32'h1, 32'hFFFF_FFFF, 0, 0, 0); tick;
      drive(0, 0, 0, 1, 0, 5); tick;
      check("reg0_a", rd_data_a, 32'd0);
      check("reg0_err", {31'd0, err_multi}, 32'd0);

      drive(1, 32'h0000_0100, 32'h0000_0088, 0, 0, 0); tick;
      drive(1, 32'h0000_0200, 32'h0000_0099, 0, 0, 0); tick;
      drive(1, 32'h0000_0300, 32'h1234_5678, 0, 0, 0); tick;
      check("multi_err_rise", {31'd0, err_multi}, 32'd1);
      drive(0, 32'h0000_0300, 32'hFFFF_0000, 1, 8, 9); tick;
      check("multi_r8", rd_data_a, 32'h0000_0088);
      check("multi_r9", rd_data_b, 32'h0000_0099);
      check("multi_err_hold", {31'd0, err_multi}, 32'd1);

      drive(1, 32'h0000_0008, 32'h0000_0011, 0, 0, 0); tick;
      drive(1, 32'h0000_0008, 32'hA5A5_A5A5, 1, 3, 3); tick;
      check("same_cycle_a", rd_data_a, BYPASS ? 32'hA5A5_A5A5 : 32'h0000_0011);
      check("same_cycle_b", rd_data_b, BYPASS ? 32'hA5A5_A5A5 : 32'h0000_0011);
      drive(0, 0, 0, 1, 3, 8); tick;
      check("after_write_a", rd_data_a, 32'hA5A5_A5A5);

      drive(0, 0, 0, 1, 5, 9); tick;
      drive(0, 0, 0, 0, 3, 3); tick;
      check("pulse_valid_low", {31'd0, rd_valid}, 32'd0);
      check("pulse_hold_a", rd_data_a, 32'hDEAD_BEEF);
      check("pulse_hold_b", rd_data_b, 32'h0000_0099);

      rst = 1'b1;
      drive(1, 32'h0000_0040, 32'h5555_5555, 1, 5, 9); tick;
      check("midrst_valid", {31'd0, rd_valid}, 32'd0);
      check("midrst_a", rd_data_a, 32'd0);
      check("midrst_err", {31'd0, err_multi}, 32'd0);
      rst = 1'b0;
      drive(0, 0, 0, 1, 5, 6); tick;
      check("post_rst_r5", rd_data_a, 32'd0);
      check("post_rst_r6", rd_data_b, 32'd0);

      // back-to-back traffic, model-checked every cycle
      for (int i = 0; i < 60; i++) begin
         logic [31:0] oh;
         case (i % 5)
            0: oh = 32'd1 << $urandom_range(31);
            1: oh = 32'd1 << $urandom_range(31);
            2: oh = (i % 15 == 2) ? 32'h0000_0300 : 32'd1 << $urandom_range(31);
            3: oh = 32'h0;
            default: oh = 32'd1 << $urandom_range(31);
         endcase
         drive(1'($urandom_range(1)), oh, $urandom, 1'($urandom_range(3) != 0),
               5'($urandom_range(31)), 5'($urandom_range(31)));
         tick;
      end
      drive(0, 0, 0, 0, 0, 0); tick;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
